jtdsp16_do_ctl: RTL and testbench



---
 rtl/jtdsp16_do_ctl.sv | 56 +++++
 tb/tb_jtdsp16_do_ctl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/jtdsp16_do_ctl.sv
// jtdsp16_do_ctl: do/redo loop sequencer driving XAAU loop-control strobes
module jtdsp16_do_ctl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ph1,
  input  logic        do_en,
  input  logic        redo,
  input  logic [10:0] do_data,
  input  logic        do_stall,
  output logic        do_start,
  output logic        do_save,
  output logic        do_redo,
  output logic        do_out,
  output logic        do_short,
  output logic [3:0]  do_pc,
  output logic        do_busy,
  output logic [6:0]  debug_k
);
  logic       active;
  logic [3:0] n_reg;
  logic [6:0] k_cnt;
  logic [3:0] n;
  logic [6:0] k;
  logic       acc;
  logic       last;
  assign n        = do_data[10:7];
  assign k        = do_data[6:0];
  assign acc      = do_en & ~active & (k != 7'd0) & (redo ? n_reg != 4'd0 : n != 4'd0);
  assign last     = do_pc == n_reg - 4'd1;
  assign do_start = acc;
  assign do_save  = acc & ~redo;
  assign do_redo  = acc & redo;
  assign do_out   = active & ~do_stall & last & (k_cnt == 7'd1);
  assign do_short = n_reg == 4'd1;
  assign do_busy  = active;
  assign debug_k  = k_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      n_reg  <= 4'd0;
      k_cnt  <= 7'd0;
      do_pc  <= 4'd0;
    end else if (ph1) begin
      if (acc) begin
        active <= 1'b1;
        do_pc  <= 4'd0;
        k_cnt  <= k;
        n_reg  <= redo ? n_reg : n;
      end else if (active && !do_stall) begin
        do_pc  <= last ? 4'd0 : do_pc + 4'd1;
        k_cnt  <= last ? k_cnt - 7'd1 : k_cnt;
        active <= !(last && k_cnt == 7'd1);
      end
    end
  end
endmodule

// File: tb/tb_jtdsp16_do_ctl.sv
// tb_jtdsp16_do_ctl: scoreboard bench; stimulus queues expected outputs, monitor compares
module tb_jtdsp16_do_ctl;
  logic        clk = 1'b0;
  logic        rst, ph1, do_en, redo, do_stall;
  logic [10:0] do_data;
  logic        do_start, do_save, do_redo, do_out, do_short, do_busy;
  logic [3:0]  do_pc;
  logic [6:0]  debug_k;
  int          errors = 0;
  int          checks = 0;
  int          step = 0;
  logic [16:0] exp_q[$];
  int          id_q[$];

  jtdsp16_do_ctl dut (
    .clk(clk), .rst(rst), .ph1(ph1), .do_en(do_en), .redo(redo),
    .do_data(do_data), .do_stall(do_stall), .do_start(do_start),
    .do_save(do_save), .do_redo(do_redo), .do_out(do_out),
    .do_short(do_short), .do_pc(do_pc), .do_busy(do_busy), .debug_k(debug_k)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] ex(input logic st, sv, rd, o, sh, input logic [3:0] pc,
                                     input logic b, input logic [6:0] k);
    return {st, sv, rd, o, sh, pc, b, k};
  endfunction

  task automatic cyc(input logic r, p, e, rd, input logic [3:0] n, input logic [6:0] k,
                     input logic st, input logic [16:0] x);
    @(posedge clk);
    #1;
    rst = r; ph1 = p; do_en = e; redo = rd; do_data = {n, k}; do_stall = st;
    exp_q.push_back(x);
    id_q.push_back(step);
    step++;
  endtask

  // {start,save,redo,out,short,pc,busy,k} is sampled mid-cycle, after inputs settle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [16:0] act, want;
      int id;
      act  = {do_start, do_save, do_redo, do_out, do_short, do_pc, do_busy, debug_k};
      want = exp_q.pop_front();
      id   = id_q.pop_front();
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL step%0d: got st=%b sv=%b rd=%b out=%b sh=%b pc=%0d busy=%b k=%0d, want st=%b sv=%b rd=%b out=%b sh=%b pc=%0d busy=%b k=%0d",
                 id, act[16], act[15], act[14], act[13], act[12], act[11:8], act[7], act[6:0],
                 want[16], want[15], want[14], want[13], want[12], want[11:8], want[7], want[6:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; ph1 = 1'b1; do_en = 1'b0; redo = 1'b0; do_data = 11'd0; do_stall = 1'b0;
    repeat (2) @(posedge clk);
    // reset state, redo with no prior do
    cyc(0,1,0,0,0,0,0, ex(0,0,0,0,0,0,0,0));
    cyc(0,1,1,1,0,2,0, ex(0,0,0,0,0,0,0,0));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,0,0,0,0,0));
    // reset mid-loop
    cyc(0,1,1,0,3,5,0, ex(1,1,0,0,0,0,0,0));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,0,0,0,1,5));
    cyc(1,1,0,0,0,0,0, ex(0,0,0,0,0,1,1,5));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,0,0,0,0,0));
    cyc(0,1,1,1,0,2,0, ex(0,0,0,0,0,0,0,0));
    // basic do N=3 K=2, nested do and redo rejected while active
    cyc(0,1,1,0,3,2,0, ex(1,1,0,0,0,0,0,0));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,0,0,0,1,2));
    cyc(0,1,1,0,1,1,0, ex(0,0,0,0,0,1,1,2));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,0,0,2,1,2));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,0,0,0,1,1));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,0,0,1,1,1));
    cyc(0,1,1,1,0,3,0, ex(0,0,0,1,0,2,1,1));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,0,0,0,0,0));
    // do N=4 K=1, redo K=3 accepted right after do_out
    cyc(0,1,1,0,4,1,0, ex(1,1,0,0,0,0,0,0));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,0,0,0,1,1));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,0,0,1,1,1));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,0,0,2,1,1));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,1,0,3,1,1));
    cyc(0,1,1,1,0,3,0, ex(1,0,1,0,0,0,0,0));
    for (int i = 0; i < 12; i++)
      cyc(0,1,0,0,0,0,0, ex(0,0,0,1'(i == 11),0,4'(i % 4),1,7'(3 - i / 4)));
    // rejected: K=0, N=0, redo K=0
    cyc(0,1,1,0,2,0,0, ex(0,0,0,0,0,0,0,0));
    cyc(0,1,1,0,0,3,0, ex(0,0,0,0,0,0,0,0));
    cyc(0,1,1,1,0,0,0, ex(0,0,0,0,0,0,0,0));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,0,0,0,0,0));
    // short loop N=1 K=4 with 2-cycle stall in iteration 2
    cyc(0,1,1,0,1,4,0, ex(1,1,0,0,0,0,0,0));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,0,1,0,1,4));
    cyc(0,1,0,0,0,0,1, ex(0,0,0,0,1,0,1,3));
    cyc(0,1,0,0,0,0,1, ex(0,0,0,0,1,0,1,3));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,0,1,0,1,3));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,0,1,0,1,2));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,1,1,0,1,1));
    cyc(0,1,0,0,0,0,1, ex(0,0,0,0,1,0,0,0));
    // stall suppresses do_out on the final cycle
    cyc(0,1,1,0,1,1,0, ex(1,1,0,0,1,0,0,0));
    cyc(0,1,0,0,0,0,1, ex(0,0,0,0,1,0,1,1));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,1,1,0,1,1));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,0,1,0,0,0));
    // ph1 gating, do N=2 K=2
    cyc(0,1,1,0,2,2,0, ex(1,1,0,0,1,0,0,0));
    cyc(0,0,0,0,0,0,0, ex(0,0,0,0,0,0,1,2));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,0,0,0,1,2));
    cyc(0,0,0,0,0,0,0, ex(0,0,0,0,0,1,1,2));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,0,0,1,1,2));
    cyc(0,0,0,0,0,0,0, ex(0,0,0,0,0,0,1,1));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,0,0,0,1,1));
    cyc(0,0,0,0,0,0,0, ex(0,0,0,1,0,1,1,1));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,1,0,1,1,1));
    cyc(0,0,0,0,0,0,0, ex(0,0,0,0,0,0,0,0));
    cyc(0,1,0,0,0,0,0, ex(0,0,0,0,0,0,0,0));
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
